// File: rtl/mure_block_builder.sv
// Groups retired uops into trace-encoder instruction blocks; merges sequential STD
// instructions and emits one registered descriptor per closed block.
module mure_block_builder #(
  parameter int XLEN        = 32,
  parameter int IRETIRE_LEN = 32,
  parameter int ITYPE_LEN   = 3,
  parameter int CAUSE_LEN   = 5,
  parameter int PRIV_LEN    = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   uop_valid_i,
  output logic                   uop_ready_o,
  input  logic [XLEN-1:0]        uop_pc_i,
  input  logic [ITYPE_LEN-1:0]   uop_itype_i,
  input  logic                   uop_compressed_i,
  input  logic [CAUSE_LEN-1:0]   uop_cause_i,
  input  logic [XLEN-1:0]        uop_tval_i,
  input  logic [PRIV_LEN-1:0]    uop_priv_i,
  output logic                   blk_valid_o,
  input  logic                   blk_ready_i,
  output logic [XLEN-1:0]        blk_iaddr_o,
  output logic [IRETIRE_LEN-1:0] blk_iretire_o,
  output logic                   blk_ilastsize_o,
  output logic [ITYPE_LEN-1:0]   blk_itype_o,
  output logic [CAUSE_LEN-1:0]   blk_cause_o,
  output logic [XLEN-1:0]        blk_tval_o,
  output logic [PRIV_LEN-1:0]    blk_priv_o,
  output logic [1:0]             dbg_state_o
);

  // Handshake: a uop moves on a cycle where uop_valid_i && uop_ready_o; a descriptor
  // moves where blk_valid_o && blk_ready_i, and blk_* hold stable until then.

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_e;

  localparam logic [ITYPE_LEN-1:0] IT_STD = ITYPE_LEN'(0);
  localparam logic [ITYPE_LEN-1:0] IT_EXC = ITYPE_LEN'(1);
  localparam logic [ITYPE_LEN-1:0] IT_INT = ITYPE_LEN'(2);
  localparam logic [ITYPE_LEN-1:0] IT_RES = ITYPE_LEN'(7);

  state_e                 state_q, state_d;
  logic                   pend_q, pend_d;
  logic [ITYPE_LEN-1:0]   pend_itype_q, pend_itype_d;
  logic [XLEN-1:0]        iaddr_q, iaddr_d;
  logic [IRETIRE_LEN-1:0] iretire_q, iretire_d;
  logic                   last_q, last_d;
  logic [PRIV_LEN-1:0]    priv_q, priv_d;

  logic                   slot_free, acc, is_std, is_trap, mergeable;
  logic [IRETIRE_LEN-1:0] sz;
  logic [IRETIRE_LEN:0]   sum;
  logic [XLEN-1:0]        next_pc;

  logic                   emit, e_last;
  logic [XLEN-1:0]        e_iaddr, e_tval;
  logic [IRETIRE_LEN-1:0] e_iretire;
  logic [ITYPE_LEN-1:0]   e_itype;
  logic [CAUSE_LEN-1:0]   e_cause;
  logic [PRIV_LEN-1:0]    e_priv;

  assign slot_free   = !blk_valid_o || blk_ready_i;
  // A pending single-instruction block holds off new uops until it has been emitted.
  assign uop_ready_o = !rst_i && !flush_i && slot_free && !pend_q;
  assign acc         = uop_valid_i && uop_ready_o;
  assign is_std      = (uop_itype_i == IT_STD) || (uop_itype_i == IT_RES);
  assign is_trap     = (uop_itype_i == IT_EXC) || (uop_itype_i == IT_INT);
  assign sz          = uop_compressed_i ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
  assign sum         = {1'b0, iretire_q} + {1'b0, sz};
  assign next_pc     = iaddr_q + (XLEN'(iretire_q) << 1);
  assign mergeable   = (state_q == COUNT) && (uop_pc_i == next_pc) &&
                       (uop_priv_i == priv_q) && !sum[IRETIRE_LEN];
  assign dbg_state_o = {pend_q, state_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      pend_itype_q <= '0;
      iaddr_q      <= '0;
      iretire_q    <= '0;
      last_q       <= 1'b0;
      priv_q       <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_itype_q <= pend_itype_d;
      iaddr_q      <= iaddr_d;
      iretire_q    <= iretire_d;
      last_q       <= last_d;
      priv_q       <= priv_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_itype_d = pend_itype_q;
    iaddr_d      = iaddr_q;
    iretire_d    = iretire_q;
    last_d       = last_q;
    priv_d       = priv_q;
    if (pend_q) begin
      if (slot_free) begin
        pend_d  = 1'b0;
        state_d = IDLE;
      end
    end else if (flush_i) begin
      // A flush against a stalled output slot waits until the slot frees.
      if (state_q == COUNT && slot_free) state_d = IDLE;
    end else if (acc) begin
      if (is_trap) begin
        state_d = IDLE;
      end else if (mergeable) begin
        if (is_std) begin
          iretire_d = sum[IRETIRE_LEN-1:0];
          last_d    = !uop_compressed_i;
        end else begin
          state_d = IDLE;
        end
      end else if (is_std || state_q == COUNT) begin
        state_d   = COUNT;
        iaddr_d   = uop_pc_i;
        iretire_d = sz;
        last_d    = !uop_compressed_i;
        priv_d    = uop_priv_i;
        if (!is_std) begin
          pend_d       = 1'b1;
          pend_itype_d = uop_itype_i;
        end
      end
    end
  end

  always_comb begin
    emit      = 1'b0;
    e_iaddr   = iaddr_q;
    e_iretire = iretire_q;
    e_last    = last_q;
    e_itype   = IT_STD;
    e_cause   = '0;
    e_tval    = '0;
    e_priv    = priv_q;
    if (pend_q) begin
      emit    = slot_free;
      e_itype = pend_itype_q;
    end else if (flush_i) begin
      emit = (state_q == COUNT) && slot_free;
    end else if (acc) begin
      if (is_trap) begin
        emit    = 1'b1;
        e_itype = uop_itype_i;
        e_cause = uop_cause_i;
        e_tval  = uop_tval_i;
        if (state_q == IDLE) begin
          e_iaddr   = uop_pc_i;
          e_iretire = '0;
          e_last    = 1'b0;
          e_priv    = uop_priv_i;
        end
      end else if (mergeable) begin
        if (!is_std) begin
          emit      = 1'b1;
          e_iretire = sum[IRETIRE_LEN-1:0];
          e_last    = !uop_compressed_i;
          e_itype   = uop_itype_i;
        end
      end else if (state_q == COUNT) begin
        emit = 1'b1;
      end else if (!is_std) begin
        emit      = 1'b1;
        e_iaddr   = uop_pc_i;
        e_iretire = sz;
        e_last    = !uop_compressed_i;
        e_itype   = uop_itype_i;
        e_priv    = uop_priv_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blk_valid_o     <= 1'b0;
      blk_iaddr_o     <= '0;
      blk_iretire_o   <= '0;
      blk_ilastsize_o <= 1'b0;
      blk_itype_o     <= '0;
      blk_cause_o     <= '0;
      blk_tval_o      <= '0;
      blk_priv_o      <= '0;
    end else if (emit) begin
      blk_valid_o     <= 1'b1;
      blk_iaddr_o     <= e_iaddr;
      blk_iretire_o   <= e_iretire;
      blk_ilastsize_o <= e_last;
      blk_itype_o     <= e_itype;
      blk_cause_o     <= e_cause;
      blk_tval_o      <= e_tval;
      blk_priv_o      <= e_priv;
    end else if (blk_ready_i) begin
      blk_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/mure_block_builder.md
# mure_block_builder

Groups retired instructions from the uop FIFO into instruction blocks for the trace encoder. Consumes one uop entry per cycle (pc, itype, compressed, cause, tval, priv). Merges consecutive sequential STD instructions into one block. Emits one registered block descriptor (iaddr, iretire, ilastsize, itype, cause, tval, priv) whenever a block is closed by a control-flow itype, a trap, a discontinuity, a privilege change, counter saturation or a flush.

## Interface
Parameters:
- XLEN, 32: address width.
- IRETIRE_LEN, 32: iretire counter width, in halfwords.
- ITYPE_LEN, 3: itype width, using the itype_e encoding.
- CAUSE_LEN, 5: trap cause width.
- PRIV_LEN, 2: privilege width.

Ports:
- clk_i  in  1  clock. Single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  closes any open block.
- uop_valid_i  in  1  uop available.
- uop_ready_o  out  1  uop accepted when valid && ready.
- uop_pc_i  in  XLEN  instruction address.
- uop_itype_i  in  ITYPE_LEN  itype of the uop.
- uop_compressed_i  in  1  1 = 16-bit instruction.
- uop_cause_i  in  CAUSE_LEN  trap cause.
- uop_tval_i  in  XLEN  trap value.
- uop_priv_i  in  PRIV_LEN  privilege level.
- blk_valid_o  out  1  block descriptor valid.
- blk_ready_i  in  1  consumer accepts the descriptor.
- blk_iaddr_o  out  XLEN  first instruction address of the block.
- blk_iretire_o  out  IRETIRE_LEN  halfwords retired in the block.
- blk_ilastsize_o  out  1  size of the last retired instruction: 0 = 2 bytes, 1 = 4 bytes.
- blk_itype_o  out  ITYPE_LEN  block termination type.
- blk_cause_o  out  CAUSE_LEN  trap cause; 0 unless itype is EXC or INT.
- blk_tval_o  out  XLEN  trap value; 0 unless itype is EXC or INT.
- blk_priv_o  out  PRIV_LEN  privilege of the block.

## Operation
- State: FSM IDLE/COUNT plus open-block registers iaddr, iretire, lastsize and priv.
- Size: a uop adds sz = 1 if compressed, else 2.
- Accept condition: acc = uop_valid_i && uop_ready_o.
- Ready: uop_ready_o = !rst_i && !flush_i && (!blk_valid_o || blk_ready_i).
- IDLE, acc with STD (RES is treated as STD):
  - Open a block: iaddr = pc, iretire = sz, lastsize = !compressed, priv = uop_priv_i.
  - Go to COUNT.
- IDLE, acc with NTB, TB, UIJ or ERET:
  - Emit at once: iaddr = pc, iretire = sz, itype = uop itype.
  - Stay in IDLE.
- IDLE, acc with EXC or INT:
  - Emit iaddr = pc, iretire = 0, ilastsize = 0, itype, cause, tval.
  - The trapping instruction is not counted.
- COUNT, acc with STD:
  - Merge when pc == iaddr + (iretire<<1) (modulo 2^XLEN), priv is unchanged, and iretire + sz ≤ 2^IRETIRE_LEN − 1. Merging adds sz to iretire and updates lastsize.
  - Otherwise, emit the open block as STD and open a new block from this uop in the same cycle.
- COUNT, acc with NTB, TB, UIJ or ERET:
  - If the merge conditions hold, add the instruction and emit with the uop itype, then go to IDLE.
  - Otherwise, emit the open block as STD and emit nothing else. The uop then becomes a new open block; it is emitted as a single-instruction block on the next free slot before further uops are accepted.
- COUNT, acc with EXC or INT:
  - Emit the open block's iaddr, iretire and lastsize with the uop's itype, cause and tval.
  - Go to IDLE.
- flush_i in COUNT: emit the open block as STD and go to IDLE. No uop is accepted that cycle.
- flush_i in IDLE: no effect.
- Output register: blk_* is loaded on emission and held stable while blk_valid_o && !blk_ready_i.
- blk_valid_o clears on blk_ready_i unless a new emission loads in the same cycle.

## Timing
- Reset:
  - All blk_* outputs are 0 and the FSM is in IDLE.
  - The open-block registers are cleared.
  - uop_ready_o is 0 while rst_i is high.
- Reset mid-block: the open block is discarded and nothing is emitted.
- Latency: blk_valid_o rises in the cycle after the closing uop or flush is sampled.
- Throughput: 1 uop per cycle with blk_ready_i held high.
- Pending single-instruction case (COUNT, non-mergeable NTB/TB/UIJ/ERET):
  - uop_ready_o is forced to 0 for one extra cycle.
  - The second descriptor appears the cycle after the first is taken.
- Simultaneous flush_i and uop_valid_i: flush wins and the uop waits.

## Test plan
- Control-flow close: STD 4B at 0x1000, 0x1004, 0x1008, then TB compressed at 0x100C → one block: iaddr 0x1000, iretire 7, ilastsize 0, itype 5. FSM returns to IDLE.
- Exception close: STD 4B at 0x2000, then EXC at pc 0x2004 with cause 2, tval 0xDEAD → block: iaddr 0x2000, iretire 2, itype 1, cause 2, tval 0xDEAD.
- Discontinuity and flush: STD at 0x3000, then STD at 0x4000 → STD block (0x3000, iretire 2) one cycle after the second accept. Then flush_i → block (0x4000, iretire 2, itype 0).
- Backpressure: blk_ready_i = 0 with a descriptor pending → uop_ready_o = 0 and outputs stable for 5 cycles. Raising blk_ready_i drains the descriptor and restores ready.
- Saturation, IRETIRE_LEN = 4: eight 4B STDs from 0x5000 → first block (0x5000, iretire 14) on the 8th accept. The open block is then 0x501C with iretire 2.
- Reset mid-block: two STDs, then rst_i for 1 cycle → no block is emitted and all outputs are 0. The next STD at 0x6000 starts a fresh block.
